// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entry layout keeps the PC pair with the returned instruction and a filled flag.
package fetch_pkg;

  localparam int              DEPTH_DEFAULT = 4;
  localparam int              XLEN_DEFAULT  = 32;
  localparam logic [31:0]     NOP_INSTR     = 32'h00000013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] inc_pc;
    logic [XLEN_DEFAULT-1:0] instr;
    logic                    filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue between the PC block and decode; 2-cycle fill latency with 1-cycle memory.
// Stalls the PC (pc_en=0) when the buffer plus in-flight requests reach DEPTH; flush discards wrong path.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] fetch_inc_pc,
  input  logic            flush,
  output logic            pc_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inc_pc
);

  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  entries [DEPTH];
  fetch_entry_t  head_e;
  logic [PW-1:0] head, tail, fill;
  logic [CW-1:0] occ, out_cnt, drop_cnt;
  logic          issue, deq, rsp, drop, fill_en;

  assign head_e = entries[head];

  // Gated by rst so the PC and memory see no request while reset is held.
  assign imem_req  = !rst && !flush && (occ < FULL);
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_ready;
  assign pc_en     = issue || (flush && !rst);

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp     = imem_rvalid && (out_cnt != '0);
  assign drop    = rsp && (drop_cnt != '0);
  assign fill_en = rsp && (drop_cnt == '0);

  assign id_valid  = (occ != '0) && head_e.filled && !flush;
  assign deq       = id_valid && id_ready;
  assign id_instr  = id_valid ? head_e.instr  : NOP_INSTR;
  assign id_pc     = id_valid ? head_e.pc     : '0;
  assign id_inc_pc = id_valid ? head_e.inc_pc : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      occ      <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      occ      <= '0;
      out_cnt  <= out_cnt - CW'(rsp);
      // Everything still in flight after this cycle belongs to the wrong path.
      drop_cnt <= out_cnt - CW'(rsp);
      for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
    end else begin
      if (issue) begin
        entries[tail].pc     <= fetch_pc;
        entries[tail].inc_pc <= fetch_inc_pc;
        entries[tail].filled <= 1'b0;
        tail                 <= tail + PW'(1);
      end
      if (fill_en) begin
        entries[fill].instr  <= imem_rdata;
        entries[fill].filled <= 1'b1;
        fill                 <= fill + PW'(1);
      end
      if (deq)  head     <= head + PW'(1);
      if (drop) drop_cnt <= drop_cnt - CW'(1);
      occ     <= occ + CW'(issue) - CW'(deq);
      out_cnt <= out_cnt + CW'(issue) - CW'(rsp);
    end
  end

  rsp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && out_cnt == '0))
    else $error("fetch_queue: imem_rvalid with no outstanding request");

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: PC block and variable-latency memory are modelled here.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc, fetch_inc_pc;
  logic        flush;
  logic        pc_en, imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_inc_pc;

  fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .fetch_pc(fetch_pc), .fetch_inc_pc(fetch_inc_pc), .flush(flush),
    .pc_en(pc_en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_inc_pc(id_inc_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t  sb[$];
  mreq_t mem_q[$];

  int          checks = 0, errors = 0;
  int          cyc = 0, lat = 1;
  int          n_iss, n_deq, step_idx, first_valid;
  logic        have_first;
  logic [31:0] first_deq_pc, redirect;
  logic        obs_req, obs_pc_en, obs_valid;
  logic [31:0] obs_id_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2] ^ 30'h02A5C3F1, 2'b11};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_iss = 0; n_deq = 0; step_idx = 0; first_valid = -1;
    have_first = 1'b0; first_deq_pc = '0;
  endtask

  // One clock: memory drives its response, outputs are observed mid-cycle,
  // then the PC model advances after the edge.
  task automatic step();
    logic iss, dq;
    exp_t e;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    fetch_inc_pc = fetch_pc + 32'd4;
    @(negedge clk);
    iss       = imem_req && imem_ready;
    dq        = id_valid && id_ready;
    obs_req   = imem_req;
    obs_pc_en = pc_en;
    obs_valid = id_valid;
    obs_id_pc = id_pc;
    if (id_valid && first_valid < 0) first_valid = step_idx;
    if (dq) begin
      n_deq++;
      check("deq_sb_level", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (!have_first) begin
          have_first   = 1'b1;
          first_deq_pc = id_pc;
        end
        check("id_pc", id_pc, e.pc);
        check("id_inc_pc", id_inc_pc, e.inc);
        check("id_instr", id_instr, e.instr);
      end
    end
    if (iss) begin
      n_iss++;
      sb.push_back('{fetch_pc, fetch_pc + 32'd4, instr_of(fetch_pc)});
      mem_q.push_back('{fetch_pc, cyc + lat});
    end
    if (imem_rvalid) mem_q.delete(0);
    if (flush) sb.delete();
    @(posedge clk);
    #1;
    cyc++;
    step_idx++;
    if (obs_pc_en) fetch_pc = flush ? redirect : fetch_pc + 32'd4;
    fetch_inc_pc = fetch_pc + 32'd4;
  endtask

  task automatic apply_reset(input logic [31:0] rpc);
    rst = 1'b1; flush = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    sb.delete(); mem_q.delete();
    fetch_pc = rpc; fetch_inc_pc = rpc + 32'd4;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
  endtask

  task automatic drain(input string tag);
    imem_ready = 1'b0; id_ready = 1'b1; flush = 1'b0;
    repeat (12) step();
    check(tag, 32'(sb.size()), 32'd0);
    imem_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; redirect = '0;
    imem_ready = 1'b1; id_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0;
    fetch_pc = '0; fetch_inc_pc = 32'd4;
    clear_stats();
    #3;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, NOP_INSTR);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_inc_pc", id_inc_pc, 32'd0);

    // Streaming with 1-cycle memory: first valid two cycles after release.
    apply_reset(32'h0);
    lat = 1;
    repeat (12) step();
    check("p1_first_valid", 32'(first_valid), 32'd2);
    check("p1_deq_count", 32'(n_deq), 32'd10);
    check("p1_first_pc", first_deq_pc, 32'h0);
    drain("p1_drain");

    // Decode stalled: buffer fills to DEPTH, PC stops, then drains in order.
    apply_reset(32'h0);
    lat = 1; id_ready = 1'b0; imem_ready = 1'b1;
    repeat (10) step();
    check("p2_issues", 32'(n_iss), 32'd4);
    check("p2_imem_req", 32'(obs_req), 32'd0);
    check("p2_pc_en", 32'(obs_pc_en), 32'd0);
    check("p2_id_valid", 32'(obs_valid), 32'd1);
    check("p2_id_pc_held", obs_id_pc, 32'h0);
    id_ready = 1'b1; n_deq = 0;
    repeat (8) step();
    check("p2_drain_deqs", 32'(n_deq), 32'd8);
    check("p2_first_pc", first_deq_pc, 32'h0);
    drain("p2_drain");

    // Three requests in flight, flush: all three responses discarded.
    apply_reset(32'h10);
    lat = 4; id_ready = 1'b1; imem_ready = 1'b1;
    repeat (3) step();
    check("p3_issues", 32'(n_iss), 32'd3);
    redirect = 32'h100; flush = 1'b1;
    step();
    check("p3_flush_req", 32'(obs_req), 32'd0);
    check("p3_flush_pc_en", 32'(obs_pc_en), 32'd1);
    check("p3_flush_valid", 32'(obs_valid), 32'd0);
    flush = 1'b0;
    repeat (14) step();
    drain("p3_drain");
    check("p3_has_deq", 32'(have_first), 32'd1);
    check("p3_first_pc", first_deq_pc, 32'h100);

    // Flush coincides with a response while two are outstanding: one more dropped.
    apply_reset(32'h40);
    lat = 2; id_ready = 1'b1; imem_ready = 1'b1;
    repeat (2) step();
    redirect = 32'h200; flush = 1'b1;
    step();
    check("p4_flush_pc_en", 32'(obs_pc_en), 32'd1);
    flush = 1'b0; n_deq = 0;
    repeat (2) step();
    drain("p4_drain");
    check("p4_deqs", 32'(n_deq), 32'd2);
    check("p4_first_pc", first_deq_pc, 32'h200);

    // Memory ready toggling: pc_en follows accepted requests, PCs stay contiguous.
    apply_reset(32'h0);
    lat = 1; id_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      imem_ready = (i % 2 == 0);
      step();
      check("p5_pc_en", 32'(obs_pc_en), 32'(imem_ready));
    end
    drain("p5_drain");
    check("p5_deqs", 32'(n_deq), 32'd6);

    // Asynchronous reset mid-burst with three entries allocated.
    apply_reset(32'h0);
    lat = 1; id_ready = 1'b0; imem_ready = 1'b1;
    repeat (3) step();
    #2;
    check("p6_pre_valid", 32'(id_valid), 32'd1);
    rst = 1'b1; imem_rvalid = 1'b0;
    #1;
    check("p6_id_valid", 32'(id_valid), 32'd0);
    check("p6_imem_req", 32'(imem_req), 32'd0);
    check("p6_pc_en", 32'(pc_en), 32'd0);
    check("p6_id_instr", id_instr, NOP_INSTR);
    apply_reset(32'h0);
    id_ready = 1'b1; imem_ready = 1'b1;
    repeat (8) step();
    check("p6_recover_deqs", 32'(n_deq), 32'd6);
    check("p6_first_pc", first_deq_pc, 32'h0);
    drain("p6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
